cla_pipe_adder: RTL
===================

// Module: cla_pipe_adder
// PURPOSE
//   Two-stage pipelined WIDTH-bit add/subtract unit for the datapath ALU.
//   Stage 1 registers per-bit generate/propagate and 4-bit group G/P from the CLA cells.
//   Stage 2 resolves group carries by lookahead and produces sum and flags.
//   Sits between the register-read/operand mux (upstream) and ALU result mux (downstream),
//   with valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of GROUP
//   GROUP  4   bits per lookahead group (fixed at 4; other values unsupported)
// PORTS
//   CLK        in   1      rising-edge clock
//   reset_n    in   1      asynchronous reset, active low
//   in_valid   in   1      operands a, b, sub, cin are valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      1: compute a - b (b inverted, carry-in forced 1)
//   cin        in   1      carry-in; ignored when sub=1
//   out_valid  out  1      result fields valid
//   out_ready  in   1      downstream consumes result this cycle
//   s          out  WIDTH  sum/difference
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow (carry into MSB xor carry out)
//   zero       out  1      s == 0
//   neg        out  1      s[WIDTH-1]
// BEHAVIOUR
//   - Reset (async, reset_n=0): s1_valid=0, out_valid=0; all data/flag regs clear to 0.
//     Outputs read 0 while reset_n=0; in_ready=1 one cycle after reset deassertion.
//   - Transfer rules: input accepted when in_valid & in_ready; result consumed when
//     out_valid & out_ready. out_valid holds and s/cout/ovf/zero/neg stay stable
//     until consumed.
//   - Stage 1 (accept edge): b_eff = sub ? ~b : b; c0 = sub | cin.
//     Register per-bit g=a&b_eff, p=a|b_eff, x=a^b_eff, group G/P per GROUP bits, c0.
//   - Stage 2: group carry C[k+1] = G[k] | P[k]&C[k] (lookahead, no ripple across groups).
//     In-group carries are computed likewise. s = x ^ carries. Flags are derived from
//     the final s and carries, then registered.
//   - Latency: 2 cycles from accept to out_valid. Throughput: 1 result per cycle with
//     out_ready held high.
//   - Backpressure:
//     - stage2_load = s1_valid & (!out_valid | out_ready).
//     - in_ready = !s1_valid | stage2_load (combinational, no dependency on in_valid).
//   - Full pipeline with out_ready=0: in_ready=0; no data lost or duplicated.
//   - Simultaneous consume and accept on the same edge: both occur; the pipeline keeps
//     streaming.
//   - Arithmetic is modulo 2^WIDTH; all carries are WIDTH+1 internally.
//   - Reset mid-operation discards in-flight operations; no partial result appears.
// STRUCTURE
//   - cla_defs.vh (shared include): CLA_GROUP=4, ALU_WIDTH=16, and macros for group
//     count (WIDTH/GROUP).
//   - Sub-module cla_group: 4-bit combinational lookahead producing G, P and internal
//     carries. It is instantiated WIDTH/GROUP times in stage 1 (G/P) and stage 2 (carries).
//   - Top holds the two register stages and the handshake logic only.
// TESTING
//   1. a=16'h0001, b=16'h0001, sub=0, cin=0 -> 2 cycles later: s=16'h0002, cout=0,
//      ovf=0, zero=0, neg=0.
//   2. a=16'hFFFF, b=16'h0001, sub=0, cin=0 -> s=16'h0000, cout=1, zero=1, ovf=0
//      (full carry chain).
//   3. a=16'h7FFF, b=16'h0001, sub=0 -> s=16'h8000, ovf=1, neg=1, cout=0.
//      a=16'h0005, b=16'h0007, sub=1 -> s=16'hFFFE, cout=0, neg=1.
//   4. Hold out_ready=0 and stream 3 ops -> after 2 accepts in_ready=0, third held.
//      Release -> results emerge in order, each exactly once.
//   5. out_ready=1, back-to-back in_valid for 100 random ops -> one result per cycle
//      after 2-cycle fill, all equal to a+b+cin / a-b mod 2^16.
//   6. Assert reset_n=0 with both stages full -> out_valid=0 immediately. After release,
//      first new op returns its own result with no stale data.

Source files
------------

// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - shared constants for the pipelined CLA adder
package cla_pipe_adder_pkg;

   localparam int CLA_GROUP = 4;
   localparam int ALU_WIDTH = 16;

   // Number of lookahead groups for a given datapath width
   function automatic int group_count(input int width);
      return width / CLA_GROUP;
   endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// rtl/cla_pipe_adder_group.sv - 4-bit carry lookahead cell (group G/P and internal carries)
module cla_group
   import cla_pipe_adder_pkg::*;
(
   input  logic [CLA_GROUP-1:0] g,
   input  logic [CLA_GROUP-1:0] p,
   input  logic                 cin,
   output logic [CLA_GROUP-1:0] c,
   output logic                 gg,
   output logic                 pg
);

   // c[i] is the carry into bit i of the group; all terms are flat lookahead
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pg = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined carry-lookahead add/subtract unit
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NG = WIDTH / GROUP;

   logic             rdy_q;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_g, s1_p, s1_x;
   logic [NG-1:0]    s1_gg, s1_pg;
   logic             s1_c0;

   logic [WIDTH-1:0] b_eff, g_in, p_in, x_in;
   logic             c0_in;
   logic [NG-1:0]    gg_in, pg_in;
   logic [WIDTH-1:0] unused_s1_c;
   logic [NG-1:0]    unused_s2_gg, unused_s2_pg;

   logic [NG:0]      gc;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic             stage2_load;
   logic             accept;

   assign stage2_load = s1_valid & (~out_valid | out_ready);
   assign in_ready    = rdy_q & (~s1_valid | stage2_load);
   assign accept      = in_valid & in_ready;

   // Operand conditioning: subtraction is a + ~b + 1
   always_comb begin
      b_eff = sub ? ~b : b;
      c0_in = sub | cin;
      g_in  = a & b_eff;
      p_in  = a | b_eff;
      x_in  = a ^ b_eff;
   end

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group u_s1 (
         .g   (g_in[k*GROUP +: GROUP]),
         .p   (p_in[k*GROUP +: GROUP]),
         .cin (1'b0),
         .c   (unused_s1_c[k*GROUP +: GROUP]),
         .gg  (gg_in[k]),
         .pg  (pg_in[k])
      );
      cla_group u_s2 (
         .g   (s1_g[k*GROUP +: GROUP]),
         .p   (s1_p[k*GROUP +: GROUP]),
         .cin (gc[k]),
         .c   (carry[k*GROUP +: GROUP]),
         .gg  (unused_s2_gg[k]),
         .pg  (unused_s2_pg[k])
      );
   end

   // Group carries as flat sum-of-products so no carry ripples between groups
   always_comb begin
      logic term;
      logic acc;
      gc    = '0;
      term  = 1'b0;
      acc   = 1'b0;
      gc[0] = s1_c0;
      for (int k = 0; k < NG; k++) begin
         acc = 1'b0;
         for (int j = 0; j <= k; j++) begin
            term = s1_gg[j];
            for (int m = j + 1; m <= k; m++) term = term & s1_pg[m];
            acc = acc | term;
         end
         term = s1_c0;
         for (int m = 0; m <= k; m++) term = term & s1_pg[m];
         gc[k+1] = acc | term;
      end
   end

   assign carry[WIDTH] = gc[NG];
   assign sum          = s1_x ^ carry[WIDTH-1:0];

   // in_ready stays low until the first clock after reset release
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) rdy_q <= 1'b0;
      else          rdy_q <= 1'b1;
   end

   // Stage 1: capture generate/propagate terms on accept
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_x     <= '0;
         s1_gg    <= '0;
         s1_pg    <= '0;
         s1_c0    <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_g     <= g_in;
         s1_p     <= p_in;
         s1_x     <= x_in;
         s1_gg    <= gg_in;
         s1_pg    <= pg_in;
         s1_c0    <= c0_in;
      end else if (stage2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: register sum and flags; hold them until consumed
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else if (stage2_load) begin
         out_valid <= 1'b1;
         s         <= sum;
         cout      <= carry[WIDTH];
         ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
         zero      <= (sum == '0);
         neg       <= sum[WIDTH-1];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
